ahb_decoder_mux: RTL and testbench
==================================

// Module: ahb_decoder_mux
// PURPOSE
//  Parametrised AHB-Lite address decoder plus slave-to-master response multiplexer.
//  - Decodes the address phase into one-hot slave selects.
//  - Registers the selection into the data phase.
//  - Muxes HRDATA/HREADYOUT/HRESP back to the master.
//  - Contains a built-in default slave that gives the two-cycle ERROR response for unmapped accesses.
//  Sits between the single AHB-Lite master and up to 15 slaves; replaces the fixed 10-slave decoder.
// PARAMETERS
//  NUM_SLAVES  10          number of mapped slaves, 1..15 (index 15 reserved for NOMAP)
//  SLAVE_BASE  {8'h53,8'h52,8'h51,8'h50,8'h20,8'h00,...}  packed NUM_SLAVES*8, HADDR[31:24] base per slave (slave 0 in LSBs)
//  SLAVE_MASK  all 8'hFF   packed NUM_SLAVES*8, compare mask per slave (8'hFE = 32 MB region, etc.)
//  ERRCNT_W    16          width of unmapped-access counter
// PORTS
//  HCLK         in   1              bus clock
//  HRESETn      in   1              asynchronous active-low reset
//  HADDR        in   32             address-phase address
//  HTRANS       in   2              transfer type (IDLE/BUSY/NONSEQ/SEQ)
//  HSEL         out  NUM_SLAVES     one-hot slave select, combinational from HADDR
//  HSEL_NOMAP   out  1              address matches no slave
//  HRDATA_S     in   NUM_SLAVES*32  slave read data, packed
//  HREADYOUT_S  in   NUM_SLAVES     slave ready outputs
//  HRESP_S      in   NUM_SLAVES     slave responses (1 = ERROR)
//  HRDATA       out  32             muxed read data to master
//  HREADY       out  1              muxed ready to master and all slaves
//  HRESP        out  1              muxed response to master
//  MUX_SEL      out  4              registered data-phase slave index (15 = NOMAP)
//  ERR_ADDR     out  32             HADDR of most recent unmapped NONSEQ/SEQ transfer
//  ERR_COUNT    out  ERRCNT_W       saturating count of unmapped NONSEQ/SEQ transfers
// BEHAVIOUR
//  - Decode: slave i matches when (HADDR[31:24] & MASK_i) == (BASE_i & MASK_i).
//    Lowest index wins on overlap, so HSEL is always one-hot.
//    No match -> HSEL=0, HSEL_NOMAP=1. Decode ignores HTRANS.
//  - Data-phase select: MUX_SEL <= encoded match (15 if none) on HCLK rise when HREADY=1.
//    MUX_SEL holds while HREADY=0.
//  - Mux: MUX_SEL<NUM_SLAVES -> HRDATA/HREADY/HRESP from that slave. Otherwise from the default slave.
//    Default slave HRDATA is always 32'h0. An index >= NUM_SLAVES other than 15 is treated as 15.
//  - Default slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2):
//    - DS_IDLE: HREADY=1, HRESP=0. Go to DS_ERR1 if HREADY & HSEL_NOMAP & HTRANS[1].
//    - DS_ERR1: HREADY=0, HRESP=1. Go to DS_ERR2 unconditionally.
//    - DS_ERR2: HREADY=1, HRESP=1. Go to DS_ERR1 if a new NOMAP NONSEQ/SEQ transfer is sampled; otherwise DS_IDLE.
//    - IDLE/BUSY transfers to unmapped space get a zero-wait OKAY (stay in DS_IDLE).
//  - Error log: on a DS_IDLE/DS_ERR2 -> DS_ERR1 transition, ERR_ADDR <= HADDR.
//    On the same transition ERR_COUNT increments, saturating at all-ones (no wrap).
//  - Latency: select is combinational. Response appears in the data phase, one HREADY-qualified cycle after the address.
//  - Reset (async, HRESETn=0): MUX_SEL=15, FSM=DS_IDLE, ERR_ADDR=0, ERR_COUNT=0.
//    Hence HREADY=1, HRESP=0, HRDATA=0. HSEL/HSEL_NOMAP follow HADDR.
//  - Reset asserted mid-transfer (including DS_ERR1) aborts immediately to the reset values.
//    No pending error is logged.
//  - Back-to-back: a mapped transfer issued during DS_ERR2 is registered normally. The FSM then returns to DS_IDLE.
// STRUCTURE
//  - Shared package ahb_pkg:
//    - HTRANS_IDLE/BUSY/NONSEQ/SEQ localparams.
//    - HRESP_OKAY/HRESP_ERROR localparams.
//    - NOMAP_IDX = 4'd15.
//    - Default-slave state encodings.
//  - One sub-module: ahb_default_slave, containing the 3-state FSM plus the ERR_ADDR/ERR_COUNT log.
//  - Decoder, select register and mux stay in this module (generate loop over NUM_SLAVES).
// TESTING
//  - Reset: HRESETn=0 with random HADDR -> MUX_SEL=15, HREADY=1, HRESP=0, ERR_COUNT=0.
//    Release -> values unchanged until the first transfer.
//  - Mapped read: NONSEQ 0x5200_0010, slave 4 returns HRDATA 32'hCAFE_F00D with 1 wait state
//    -> HSEL=10'b00_0001_0000, MUX_SEL=4, HREADY low 1 cycle, HRDATA=CAFEF00D, HRESP=0.
//  - Unmapped NONSEQ 0x7000_0004 -> HSEL_NOMAP=1, then data phase HREADY=0/HRESP=1, then HREADY=1/HRESP=1.
//    ERR_ADDR=0x7000_0004, ERR_COUNT=1.
//  - Unmapped IDLE 0x7000_0000 -> zero-wait OKAY, ERR_COUNT unchanged.
//    Back-to-back NONSEQ 0x70.. then 0x80.. (2nd issued in DS_ERR2) -> two complete error pairs, ERR_COUNT +2.
//  - Masked/overlap config: SLAVE_MASK[0]=8'hFE, base 8'h00 -> HADDR 0x0100_0000 selects slave 0.
//    A second slave with base 8'h01 is never selected.
//  - Saturation and mid-reset: ERRCNT_W=2, 5 unmapped transfers -> ERR_COUNT=3.
//    HRESETn dropped in DS_ERR1 -> HREADY=1, HRESP=0 immediately.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and default-slave state encodings used by the
// decoder/mux slice.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [3:0] NOMAP_IDX = 4'd15;

   typedef enum logic [1:0] {
      DS_IDLE = 2'd0,
      DS_ERR1 = 2'd1,
      DS_ERR2 = 2'd2
   } ds_state_t;

   // Only NONSEQ and SEQ carry data; IDLE and BUSY must get a zero-wait OKAY.
   function automatic logic is_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped transfers,
// plus a log of the last failing address and a saturating failure count.
module ahb_default_slave
   import ahb_pkg::*;
#(
   parameter int ERRCNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hready,
   input  logic                nomap,
   input  logic [1:0]          htrans,
   input  logic [31:0]         haddr,
   output logic                ready,
   output logic                resp,
   output logic [31:0]         err_addr,
   output logic [ERRCNT_W-1:0] err_count
);

   ds_state_t state;
   logic      start;

   assign start = hready & nomap & is_active(htrans);

   // A new unmapped transfer may be accepted in DS_ERR2 since HREADY is high there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= DS_IDLE;
         ready     <= 1'b1;
         resp      <= HRESP_OKAY;
         err_addr  <= '0;
         err_count <= '0;
      end else begin
         case (state)
            DS_IDLE, DS_ERR2: begin
               if (start) begin
                  state    <= DS_ERR1;
                  ready    <= 1'b0;
                  resp     <= HRESP_ERROR;
                  err_addr <= haddr;
                  if (err_count != '1)
                     err_count <= err_count + ERRCNT_W'(1);
               end else begin
                  state <= DS_IDLE;
                  ready <= 1'b1;
                  resp  <= HRESP_OKAY;
               end
            end
            DS_ERR1: begin
               state <= DS_ERR2;
               ready <= 1'b1;
               resp  <= HRESP_ERROR;
            end
            default: begin
               state <= DS_IDLE;
               ready <= 1'b1;
               resp  <= HRESP_OKAY;
            end
         endcase
      end
   end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder with registered data-phase select and
// slave-to-master response mux; unmapped space goes to the default slave.
module ahb_decoder_mux
   import ahb_pkg::*;
#(
   parameter int                      NUM_SLAVES = 10,
   parameter logic [NUM_SLAVES*8-1:0] SLAVE_BASE =
      {8'h63, 8'h62, 8'h61, 8'h60, 8'h53, 8'h52, 8'h51, 8'h50, 8'h20, 8'h00},
   parameter logic [NUM_SLAVES*8-1:0] SLAVE_MASK = {NUM_SLAVES{8'hFF}},
   parameter int                      ERRCNT_W   = 16
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [31:0]              HADDR,
   input  logic [1:0]               HTRANS,
   output logic [NUM_SLAVES-1:0]    HSEL,
   output logic                     HSEL_NOMAP,
   input  logic [NUM_SLAVES*32-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]    HRESP_S,
   output logic [31:0]              HRDATA,
   output logic                     HREADY,
   output logic                     HRESP,
   output logic [3:0]               MUX_SEL,
   output logic [31:0]              ERR_ADDR,
   output logic [ERRCNT_W-1:0]      ERR_COUNT
);

   logic [NUM_SLAVES-1:0] match;
   logic [3:0]            addr_idx;
   logic                  ds_ready;
   logic                  ds_resp;

   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
      assign match[g] = ((HADDR[31:24] & SLAVE_MASK[g*8 +: 8]) ==
                         (SLAVE_BASE[g*8 +: 8] & SLAVE_MASK[g*8 +: 8]));
   end

   // Scanning downwards lets the lowest matching index win, keeping HSEL one-hot.
   always_comb begin
      HSEL     = '0;
      addr_idx = NOMAP_IDX;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (match[i]) begin
            HSEL     = '0;
            HSEL[i]  = 1'b1;
            addr_idx = 4'(i);
         end
      end
   end

   assign HSEL_NOMAP = ~|match;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         MUX_SEL <= NOMAP_IDX;
      else if (HREADY)
         MUX_SEL <= addr_idx;
   end

   // Any index that names no real slave falls through to the default slave.
   always_comb begin
      HRDATA = '0;
      HREADY = ds_ready;
      HRESP  = ds_resp;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (MUX_SEL == 4'(i)) begin
            HRDATA = HRDATA_S[i*32 +: 32];
            HREADY = HREADYOUT_S[i];
            HRESP  = HRESP_S[i];
         end
      end
   end

   ahb_default_slave #(
      .ERRCNT_W (ERRCNT_W)
   ) u_default_slave (
      .clk       (HCLK),
      .rst_n     (HRESETn),
      .hready    (HREADY),
      .nomap     (HSEL_NOMAP),
      .htrans    (HTRANS),
      .haddr     (HADDR),
      .ready     (ds_ready),
      .resp      (ds_resp),
      .err_addr  (ERR_ADDR),
      .err_count (ERR_COUNT)
   );

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: default 10-slave map with a response scoreboard,
// plus a 2-slave masked/overlapping instance with a 2-bit error counter.
module tb_ahb_decoder_mux;
   import ahb_pkg::*;

   localparam int NS = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [31:0]      haddr;
   logic [1:0]       htrans;
   logic [NS-1:0]    hsel;
   logic             hsel_nomap;
   logic [NS*32-1:0] hrdata_s;
   logic [NS-1:0]    hreadyout_s;
   logic [NS-1:0]    hresp_s;
   logic [31:0]      hrdata;
   logic             hready;
   logic             hresp;
   logic [3:0]       mux_sel;
   logic [31:0]      err_addr;
   logic [15:0]      err_count;

   logic        rst2_n;
   logic [31:0] haddr2;
   logic [1:0]  htrans2;
   logic [1:0]  hsel2;
   logic        nomap2;
   logic [63:0] hrdata_s2;
   logic [1:0]  hreadyout_s2;
   logic [1:0]  hresp_s2;
   logic [31:0] hrdata2;
   logic        hready2;
   logic        hresp2;
   logic [3:0]  mux_sel2;
   logic [31:0] err_addr2;
   logic [1:0]  err_count2;

   ahb_decoder_mux u_dut (
      .HCLK        (clk),
      .HRESETn     (rst_n),
      .HADDR       (haddr),
      .HTRANS      (htrans),
      .HSEL        (hsel),
      .HSEL_NOMAP  (hsel_nomap),
      .HRDATA_S    (hrdata_s),
      .HREADYOUT_S (hreadyout_s),
      .HRESP_S     (hresp_s),
      .HRDATA      (hrdata),
      .HREADY      (hready),
      .HRESP       (hresp),
      .MUX_SEL     (mux_sel),
      .ERR_ADDR    (err_addr),
      .ERR_COUNT   (err_count)
   );

   ahb_decoder_mux #(
      .NUM_SLAVES (2),
      .SLAVE_BASE ({8'h01, 8'h00}),
      .SLAVE_MASK ({8'hFF, 8'hFE}),
      .ERRCNT_W   (2)
   ) u_dut2 (
      .HCLK        (clk),
      .HRESETn     (rst2_n),
      .HADDR       (haddr2),
      .HTRANS      (htrans2),
      .HSEL        (hsel2),
      .HSEL_NOMAP  (nomap2),
      .HRDATA_S    (hrdata_s2),
      .HREADYOUT_S (hreadyout_s2),
      .HRESP_S     (hresp_s2),
      .HRDATA      (hrdata2),
      .HREADY      (hready2),
      .HRESP       (hresp2),
      .MUX_SEL     (mux_sel2),
      .ERR_ADDR    (err_addr2),
      .ERR_COUNT   (err_count2)
   );

   typedef struct packed {
      logic [31:0] rdata;
      logic        resp;
   } resp_t;

   typedef struct {
      logic [31:0]   addr;
      logic [NS-1:0] sel;
      logic          nomap;
      logic [3:0]    idx;
   } dec_vec_t;

   resp_t    sb_q[$];
   resp_t    sb_head;
   dec_vec_t vecs[12];
   bit       addr_valid = 1'b0;
   bit       dp_pending = 1'b0;
   int       checks = 0;
   int       errors = 0;

   function automatic logic [31:0] slave_data(input int i);
      return (i == 4) ? 32'hCAFE_F00D : (32'hA500_0000 | 32'(i));
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [31:0] a, input logic [1:0] t, input bit track,
                                 input logic [31:0] exp_data, input logic exp_resp);
      resp_t e;
      haddr      = a;
      htrans     = t;
      addr_valid = track;
      if (track) begin
         e.rdata = exp_data;
         e.resp  = exp_resp;
         sb_q.push_back(e);
      end
      #1;
   endtask

   task automatic go_idle();
      haddr      = 32'h7000_0000;
      htrans     = HTRANS_IDLE;
      addr_valid = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Holds the address phase until a rising edge with HREADY high, bounded.
   task automatic accept_addr();
      int n = 0;
      while (1) begin
         @(negedge clk);
         if (hready === 1'b1) break;
         n++;
         if (n > 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got hready=%b expected 1 within 20 cycles", hready);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Data phase completes on any HREADY-high cycle; compare against the oldest expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         dp_pending = 1'b0;
      end else if (hready === 1'b1) begin
         if (dp_pending) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL sb_underflow: got empty queue expected one entry");
            end else begin
               sb_head = sb_q.pop_front();
               check_output("sb_rdata", hrdata, sb_head.rdata);
               check_output("sb_resp", 32'(hresp), 32'(sb_head.resp));
            end
         end
         dp_pending = addr_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [3:0]  exp_cnt;
      logic [31:0] exp_data;

      vecs[0]  = '{32'h0000_0000, 10'b00_0000_0001, 1'b0, 4'd0};
      vecs[1]  = '{32'h20AB_CDEF, 10'b00_0000_0010, 1'b0, 4'd1};
      vecs[2]  = '{32'h5000_0000, 10'b00_0000_0100, 1'b0, 4'd2};
      vecs[3]  = '{32'h51FF_FFFF, 10'b00_0000_1000, 1'b0, 4'd3};
      vecs[4]  = '{32'h5200_0010, 10'b00_0001_0000, 1'b0, 4'd4};
      vecs[5]  = '{32'h5300_0100, 10'b00_0010_0000, 1'b0, 4'd5};
      vecs[6]  = '{32'h6000_0000, 10'b00_0100_0000, 1'b0, 4'd6};
      vecs[7]  = '{32'h6100_0000, 10'b00_1000_0000, 1'b0, 4'd7};
      vecs[8]  = '{32'h6200_0000, 10'b01_0000_0000, 1'b0, 4'd8};
      vecs[9]  = '{32'h63FF_0000, 10'b10_0000_0000, 1'b0, 4'd9};
      vecs[10] = '{32'h7000_0004, 10'b00_0000_0000, 1'b1, 4'd15};
      vecs[11] = '{32'h0100_0000, 10'b00_0000_0000, 1'b1, 4'd15};

      rst_n       = 1'b0;
      rst2_n      = 1'b0;
      haddr       = $urandom;
      htrans      = HTRANS_NONSEQ;
      hreadyout_s = '1;
      hresp_s     = '0;
      for (int i = 0; i < NS; i++) hrdata_s[i*32 +: 32] = slave_data(i);
      haddr2       = 32'h0;
      htrans2      = HTRANS_IDLE;
      hrdata_s2    = {32'hBBBB_0001, 32'hAAAA_0000};
      hreadyout_s2 = 2'b11;
      hresp_s2     = 2'b00;

      repeat (3) @(posedge clk);
      #1;
      check_output("reset_mux_sel", 32'(mux_sel), 32'd15);
      check_output("reset_hready", 32'(hready), 32'd1);
      check_output("reset_hresp", 32'(hresp), 32'd0);
      check_output("reset_hrdata", hrdata, 32'h0);
      check_output("reset_err_count", 32'(err_count), 32'd0);

      go_idle();
      @(negedge clk);
      rst_n  = 1'b1;
      rst2_n = 1'b1;
      repeat (3) cycle();
      check_output("post_reset_mux_sel", 32'(mux_sel), 32'd15);
      check_output("post_reset_hready", 32'(hready), 32'd1);
      check_output("post_reset_err_count", 32'(err_count), 32'd0);

      // Decode table: IDLE transfers so no error is logged, each tracked by the scoreboard.
      for (int i = 0; i < 12; i++) begin
         exp_data = (vecs[i].idx == 4'd15) ? 32'h0 : slave_data(int'(vecs[i].idx));
         apply_stimulus(vecs[i].addr, HTRANS_IDLE, 1'b1, exp_data, 1'b0);
         check_output("dec_hsel", 32'(hsel), 32'(vecs[i].sel));
         check_output("dec_nomap", 32'(hsel_nomap), 32'(vecs[i].nomap));
         accept_addr();
         check_output("dec_mux_sel", 32'(mux_sel), 32'(vecs[i].idx));
      end
      go_idle();
      cycle();
      check_output("dec_err_count", 32'(err_count), 32'd0);

      // Mapped read with one wait state from slave 4.
      hreadyout_s[4] = 1'b0;
      apply_stimulus(32'h5200_0010, HTRANS_NONSEQ, 1'b1, 32'hCAFE_F00D, 1'b0);
      check_output("rd_hsel", 32'(hsel), 32'(10'b00_0001_0000));
      accept_addr();
      go_idle();
      check_output("rd_mux_sel", 32'(mux_sel), 32'd4);
      check_output("rd_wait_hready", 32'(hready), 32'd0);
      cycle();
      hreadyout_s[4] = 1'b1;
      #1;
      check_output("rd_hready", 32'(hready), 32'd1);
      check_output("rd_hrdata", hrdata, 32'hCAFE_F00D);
      check_output("rd_hresp", 32'(hresp), 32'd0);
      cycle();

      // Unmapped NONSEQ: two-cycle ERROR and logged address.
      apply_stimulus(32'h7000_0004, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
      check_output("nm_nomap", 32'(hsel_nomap), 32'd1);
      check_output("nm_hsel", 32'(hsel), 32'd0);
      accept_addr();
      go_idle();
      check_output("err1_hready", 32'(hready), 32'd0);
      check_output("err1_hresp", 32'(hresp), 32'd1);
      check_output("err1_err_addr", err_addr, 32'h7000_0004);
      check_output("err1_err_count", 32'(err_count), 32'd1);
      cycle();
      check_output("err2_hready", 32'(hready), 32'd1);
      check_output("err2_hresp", 32'(hresp), 32'd1);
      cycle();
      check_output("after_err_hresp", 32'(hresp), 32'd0);

      // Unmapped IDLE gets a zero-wait OKAY and is not logged.
      apply_stimulus(32'h7000_0000, HTRANS_IDLE, 1'b1, 32'h0, 1'b0);
      accept_addr();
      go_idle();
      check_output("idle_hready", 32'(hready), 32'd1);
      check_output("idle_hresp", 32'(hresp), 32'd0);
      check_output("idle_err_count", 32'(err_count), 32'd1);
      cycle();

      // Back-to-back unmapped: second address held through ERR1, accepted in ERR2.
      apply_stimulus(32'h7000_0010, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
      accept_addr();
      apply_stimulus(32'h8000_0020, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
      check_output("b2b_err1_hready", 32'(hready), 32'd0);
      accept_addr();
      go_idle();
      check_output("b2b_err1b_hready", 32'(hready), 32'd0);
      check_output("b2b_err1b_hresp", 32'(hresp), 32'd1);
      check_output("b2b_err_count", 32'(err_count), 32'd3);
      check_output("b2b_err_addr", err_addr, 32'h8000_0020);
      cycle();
      check_output("b2b_err2b_hready", 32'(hready), 32'd1);
      check_output("b2b_err2b_hresp", 32'(hresp), 32'd1);
      cycle();

      // Mapped transfer accepted during ERR2 is registered normally.
      apply_stimulus(32'h7000_0030, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1);
      accept_addr();
      apply_stimulus(32'h2000_0040, HTRANS_NONSEQ, 1'b1, slave_data(1), 1'b0);
      accept_addr();
      go_idle();
      check_output("err2_map_mux_sel", 32'(mux_sel), 32'd1);
      check_output("err2_map_hready", 32'(hready), 32'd1);
      check_output("err2_map_hresp", 32'(hresp), 32'd0);
      check_output("err2_map_hrdata", hrdata, slave_data(1));
      check_output("err2_map_err_count", 32'(err_count), 32'd4);
      cycle();
      cycle();
      check_output("sb_empty", 32'(sb_q.size()), 32'd0);

      // Second instance: masked slave 0 covers 0x00-0x01 and shadows slave 1.
      haddr2 = 32'h0100_0000;
      #1;
      check_output("mask_hsel_01", 32'(hsel2), 32'd1);
      check_output("mask_nomap_01", 32'(nomap2), 32'd0);
      haddr2 = 32'h0000_0000;
      #1;
      check_output("mask_hsel_00", 32'(hsel2), 32'd1);
      haddr2 = 32'h0200_0000;
      #1;
      check_output("mask_hsel_02", 32'(hsel2), 32'd0);
      check_output("mask_nomap_02", 32'(nomap2), 32'd1);
      haddr2  = 32'h0100_0000;
      htrans2 = HTRANS_NONSEQ;
      cycle();
      htrans2 = HTRANS_IDLE;
      haddr2  = 32'h0200_0000;
      check_output("mask_mux_sel", 32'(mux_sel2), 32'd0);
      check_output("mask_hrdata", hrdata2, 32'hAAAA_0000);
      cycle();

      // Saturating 2-bit counter.
      for (int k = 1; k <= 5; k++) begin
         exp_cnt = (k > 3) ? 4'd3 : 4'(k);
         haddr2  = 32'h9000_0000 | 32'(k);
         htrans2 = HTRANS_NONSEQ;
         cycle();
         htrans2 = HTRANS_IDLE;
         check_output("sat_err_count", 32'(err_count2), 32'(exp_cnt));
         cycle();
         cycle();
      end
      check_output("sat_err_addr", err_addr2, 32'h9000_0005);

      // Reset dropped during ERR1 aborts the response immediately.
      haddr2  = 32'h9000_0100;
      htrans2 = HTRANS_NONSEQ;
      cycle();
      htrans2 = HTRANS_IDLE;
      check_output("mr_err1_hready", 32'(hready2), 32'd0);
      check_output("mr_err1_hresp", 32'(hresp2), 32'd1);
      #2;
      rst2_n = 1'b0;
      #1;
      check_output("mr_hready", 32'(hready2), 32'd1);
      check_output("mr_hresp", 32'(hresp2), 32'd0);
      check_output("mr_err_count", 32'(err_count2), 32'd0);
      check_output("mr_mux_sel", 32'(mux_sel2), 32'd15);
      cycle();
      rst2_n = 1'b1;
      cycle();
      cycle();
      check_output("mr_post_err_count", 32'(err_count2), 32'd0);
      check_output("mr_post_hready", 32'(hready2), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
